// File: rtl/puf_vote_ctrl.sv
// puf_vote_ctrl
//   Majority-vote wrapper around a PUF core. One challenge is evaluated
//   NUM_ROUNDS times. Each response bit is counted across the rounds, and
//   the voted response is reported together with a per-bit instability mask.
//
// Optional feature (macro PUF_VOTE_EARLY_EXIT_EN):
//   When defined, the request finishes as soon as a majority of rounds has
//   run and every round so far has returned the same response.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              block enable; low aborts an operation in progress
//   start_i               one-cycle request pulse
//   clear_i               software acknowledge for resp_valid_o / err_timeout_o
//   challenge_i           challenge, latched when start_i is accepted
//   busy_o                request in progress (ISSUE or WAIT)
//   resp_valid_o          voted result available (sticky)
//   response_o            majority-voted response
//   unstable_o            bits that disagreed across the executed rounds
//   rounds_done_o         rounds executed for the last completed request
//   err_timeout_o         core response timeout (sticky)
//   core_en_o             core enable (mirrors enable_i)
//   core_req_o            one-cycle evaluation request to the core
//   core_challenge_o      latched challenge presented to the core
//   core_resp_valid_i     core response strobe
//   core_resp_i           core response, valid with the strobe
//
// state  | meaning
// IDLE   | waiting for start_i & enable_i
// ISSUE  | core_req_o pulse, response timer loaded
// WAIT   | waiting for the core strobe or the timer to expire
// DONE   | voted result registered, resp_valid_o high
// ERR    | core timed out, err_timeout_o high until clear_i
module puf_vote_ctrl #(
  parameter int CHAL_W     = 128,
  parameter int RESP_W     = 256,
  parameter int NUM_ROUNDS = 5,
  parameter int TIMEOUT    = 1024,
  parameter int RND_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [CHAL_W-1:0] challenge_i,
  output logic              busy_o,
  output logic              resp_valid_o,
  output logic [RESP_W-1:0] response_o,
  output logic [RESP_W-1:0] unstable_o,
  output logic [RND_W-1:0]  rounds_done_o,
  output logic              err_timeout_o,
  output logic              core_en_o,
  output logic              core_req_o,
  output logic [CHAL_W-1:0] core_challenge_o,
  input  logic              core_resp_valid_i,
  input  logic [RESP_W-1:0] core_resp_i
);

  // The ISSUE cycle counts as cycle 0 of the wait window, so the down-counter
  // starts at TIMEOUT-2 on the first WAIT cycle and expires at zero.
  localparam int               TMR_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD   = (TIMEOUT >= 2) ? TMR_W'(TIMEOUT - 2) : '0;
  localparam logic [RND_W-1:0] ROUNDS_MAX = RND_W'(NUM_ROUNDS);
`ifdef PUF_VOTE_EARLY_EXIT_EN
  localparam logic [RND_W-1:0] ROUNDS_MIN = RND_W'((NUM_ROUNDS + 1) / 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [RND_W-1:0]  cnt_q   [RESP_W];
  logic [RND_W-1:0]  cnt_d   [RESP_W];
  logic [RND_W-1:0]  cnt_inc [RESP_W];
  logic [RND_W-1:0]  round_q, round_d, round_inc;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [RESP_W-1:0] unst_q, unst_d;
  logic [RESP_W-1:0] vote, split;
  logic [RND_W-1:0]  rdone_q, rdone_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              accept_start;
  logic              finish;

  // Vote datapath: counts and verdicts as they would be after accepting the
  // current core response. Registered into the result only on DONE entry.
  always_comb begin
    round_inc = round_q + 1'b1;
    for (int i = 0; i < RESP_W; i++) begin
      cnt_inc[i] = cnt_q[i] + RND_W'(core_resp_i[i]);
      vote[i]    = cnt_inc[i] > (round_inc >> 1);
      split[i]   = (cnt_inc[i] != '0) && (cnt_inc[i] != round_inc);
    end
  end

  always_comb begin
    state_d      = state_q;
    chal_d       = chal_q;
    cnt_d        = cnt_q;
    round_d      = round_q;
    tmr_d        = tmr_q;
    resp_d       = resp_q;
    unst_d       = unst_q;
    rdone_d      = rdone_q;
    valid_d      = valid_q;
    err_d        = err_q;
    accept_start = start_i && enable_i;
    finish       = (round_inc == ROUNDS_MAX);
`ifdef PUF_VOTE_EARLY_EXIT_EN
    if ((round_inc >= ROUNDS_MIN) && !(|split)) begin
      finish = 1'b1;
    end
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // start beats clear when both arrive in DONE
        if (accept_start) begin
          state_d = S_ISSUE;
          chal_d  = challenge_i;
          for (int i = 0; i < RESP_W; i++) begin
            cnt_d[i] = '0;
          end
          round_d = '0;
          valid_d = 1'b0;
        end else if (clear_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          tmr_d   = TMR_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (core_resp_valid_i) begin
          // a strobe arriving on the last timer cycle is still accepted
          cnt_d   = cnt_inc;
          round_d = round_inc;
          if (finish) begin
            state_d = S_DONE;
            resp_d  = vote;
            unst_d  = split;
            rdone_d = round_inc;
            valid_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (tmr_q == '0) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_ERR: begin
        if (clear_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      chal_q  <= '0;
      for (int i = 0; i < RESP_W; i++) begin
        cnt_q[i] <= '0;
      end
      round_q <= '0;
      tmr_q   <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      rdone_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      tmr_q   <= tmr_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      rdone_q <= rdone_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy_o           = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign core_req_o       = (state_q == S_ISSUE) && enable_i;
  assign core_en_o        = enable_i;
  assign core_challenge_o = chal_q;
  assign resp_valid_o     = valid_q;
  assign response_o       = resp_q;
  assign unstable_o       = unst_q;
  assign rounds_done_o    = rdone_q;
  assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_puf_vote_ctrl.sv
// Testbench for puf_vote_ctrl. Instance A: 3 rounds, instance B: 5 rounds,
// both 8-bit challenge/response and a 16-cycle timeout. Honours
// PUF_VOTE_EARLY_EXIT_EN when it is defined for the build.
module tb_puf_vote_ctrl;
  localparam int CW  = 8;
  localparam int RW  = 8;
  localparam int TO  = 16;
  localparam int NRA = 3;
  localparam int NRB = 5;
`ifdef PUF_VOTE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef logic [RW-1:0] rs_t [5];
  typedef struct {
    logic [RW-1:0] r0, r1, r2, er, eu;
    int            rounds;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [CW-1:0] chal;
  logic          start_s [2];
  logic          rv_s    [2];
  logic [RW-1:0] rd_s    [2];
  logic          busy [2], valid [2], err [2], cen [2], creq [2];
  logic [RW-1:0] resp [2], unst [2];
  logic [CW-1:0] cchal [2];
  logic [1:0]    rdn_a;
  logic [2:0]    rdn_b;
  logic [2:0]    rdn [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reqcnt [2] = '{0, 0};

  assign rdn[0] = {1'b0, rdn_a};
  assign rdn[1] = rdn_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (creq[0]) reqcnt[0] <= reqcnt[0] + 1;
    if (creq[1]) reqcnt[1] <= reqcnt[1] + 1;
  end

  puf_vote_ctrl #(.CHAL_W(CW), .RESP_W(RW), .NUM_ROUNDS(NRA), .TIMEOUT(TO)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(start_s[0]), .clear_i(clr),
    .challenge_i(chal), .busy_o(busy[0]), .resp_valid_o(valid[0]), .response_o(resp[0]),
    .unstable_o(unst[0]), .rounds_done_o(rdn_a), .err_timeout_o(err[0]), .core_en_o(cen[0]),
    .core_req_o(creq[0]), .core_challenge_o(cchal[0]), .core_resp_valid_i(rv_s[0]),
    .core_resp_i(rd_s[0]));

  puf_vote_ctrl #(.CHAL_W(CW), .RESP_W(RW), .NUM_ROUNDS(NRB), .TIMEOUT(TO)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .start_i(start_s[1]), .clear_i(clr),
    .challenge_i(chal), .busy_o(busy[1]), .resp_valid_o(valid[1]), .response_o(resp[1]),
    .unstable_o(unst[1]), .rounds_done_o(rdn_b), .err_timeout_o(err[1]), .core_en_o(cen[1]),
    .core_req_o(creq[1]), .core_challenge_o(cchal[1]), .core_resp_valid_i(rv_s[1]),
    .core_resp_i(rd_s[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle bound", name);
  endtask

  // Reference vote: run the rounds, optionally stop once a majority of
  // identical responses has been seen, then count ones per bit.
  function automatic void model(input rs_t r, input int n, output logic [RW-1:0] er,
                                output logic [RW-1:0] eu, output int rounds);
    int ones;
    bit same;
    rounds = n;
    if (EE) begin
      for (int k = (n + 1) / 2; k < n; k++) begin
        same = 1'b1;
        for (int j = 1; j < k; j++) if (r[j] != r[0]) same = 1'b0;
        if (same) begin
          rounds = k;
          break;
        end
      end
    end
    for (int b = 0; b < RW; b++) begin
      ones = 0;
      for (int j = 0; j < rounds; j++) ones += int'(r[j][b]);
      er[b] = (2 * ones > rounds);
      eu[b] = (ones != 0) && (ones != rounds);
    end
  endfunction

  task automatic do_start(input int idx, input logic [CW-1:0] c);
    chal = c;
    start_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_req(input int idx, input string tag);
    int w;
    w = 0;
    while (!creq[idx] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!creq[idx]) expire({tag, " core_req wait"});
  endtask

  task automatic strobe(input int idx, input logic [RW-1:0] v, input int lat);
    repeat (lat) @(negedge clk);
    rv_s[idx] = 1'b1;
    rd_s[idx] = v;
    @(negedge clk);
    rv_s[idx] = 1'b0;
  endtask

  task automatic run_txn(input int idx, input rs_t r, input logic [CW-1:0] c,
                         input logic [RW-1:0] er, input logic [RW-1:0] eu,
                         input int rounds, input string tag);
    int n, base, got;
    bit done;
    n    = (idx == 0) ? NRA : NRB;
    base = reqcnt[idx];
    do_start(idx, c);
    chk({tag, " busy after start"}, 32'(busy[idx]), 32'd1);
    chk({tag, " latched challenge"}, 32'(cchal[idx]), 32'(c));
    done = 1'b0;
    got  = 0;
    for (int k = 0; k < n && !done; k++) begin
      wait_req(idx, tag);
      strobe(idx, r[k], int'($urandom_range(1, 5)));
      got++;
      done = valid[idx];
      chk({tag, " resp_valid timing"}, 32'(valid[idx]), 32'(got == rounds));
    end
    chk({tag, " response"}, 32'(resp[idx]), 32'(er));
    chk({tag, " unstable"}, 32'(unst[idx]), 32'(eu));
    chk({tag, " rounds_done"}, 32'(rdn[idx]), 32'(rounds));
    chk({tag, " core_req pulses"}, 32'(reqcnt[idx] - base), 32'(rounds));
    chk({tag, " busy at done"}, 32'(busy[idx]), 32'd0);
  endtask

  initial begin
    vec_t          tbl [6];
    rs_t           r;
    logic [RW-1:0] er, eu;
    int            rounds, t0, w, base;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, EE ? 2 : 3};
    tbl[1] = '{8'hF0, 8'hF1, 8'h70, 8'hF0, 8'h81, 3};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 3};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 3};
    tbl[4] = '{8'h0F, 8'h3C, 8'hF0, 8'h3C, 8'hFF, 3};
    tbl[5] = '{8'h55, 8'hAA, 8'h55, 8'h55, 8'hFF, 3};

    rst = 1'b1; en = 1'b0; clr = 1'b0; chal = '0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; rv_s[i] = 1'b0; rd_s[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", 32'(busy[i]), 32'd0);
      chk("reset resp_valid", 32'(valid[i]), 32'd0);
      chk("reset err", 32'(err[i]), 32'd0);
      chk("reset core_req", 32'(creq[i]), 32'd0);
      chk("reset core_en", 32'(cen[i]), 32'd0);
      chk("reset response", 32'(resp[i]), 32'd0);
      chk("reset unstable", 32'(unst[i]), 32'd0);
      chk("reset rounds_done", 32'(rdn[i]), 32'd0);
      chk("reset challenge", 32'(cchal[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // start without enable is ignored
    do_start(0, 8'h11);
    chk("start w/o enable busy", 32'(busy[0]), 32'd0);
    chk("start w/o enable req", 32'(creq[0]), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("core_en mirror", 32'(cen[0]), 32'd1);

    // directed vectors
    for (int t = 0; t < 6; t++) begin
      r = '{tbl[t].r0, tbl[t].r1, tbl[t].r2, 8'h00, 8'h00};
      run_txn(0, r, CW'(8'h20 + t), tbl[t].er, tbl[t].eu, tbl[t].rounds, "vec");
      pulse_clear();
      chk("vec clear", 32'(valid[0]), 32'd0);
    end

    // start in WAIT ignored; then start+clear together in DONE
    do_start(0, 8'h5A);
    wait_req(0, "ws");
    @(negedge clk);
    do_start(0, 8'hC3);
    chk("start in WAIT challenge", 32'(cchal[0]), 32'h5A);
    chk("start in WAIT busy", 32'(busy[0]), 32'd1);
    strobe(0, 8'h0F, 1);
    wait_req(0, "ws");
    strobe(0, 8'h0E, 2);
    wait_req(0, "ws");
    strobe(0, 8'h1C, 1);
    chk("ws valid", 32'(valid[0]), 32'd1);
    chk("ws response", 32'(resp[0]), 32'h0E);
    chk("ws unstable", 32'(unst[0]), 32'h13);
    chal = 8'h77; clr = 1'b1; start_s[0] = 1'b1;
    @(negedge clk);
    clr = 1'b0; start_s[0] = 1'b0;
    chk("start in DONE valid drop", 32'(valid[0]), 32'd0);
    chk("start in DONE busy", 32'(busy[0]), 32'd1);
    chk("start in DONE core_req", 32'(creq[0]), 32'd1);
    chk("start in DONE challenge", 32'(cchal[0]), 32'h77);
    strobe(0, 8'h81, 1);
    wait_req(0, "sd");
    strobe(0, 8'h80, 3);
    wait_req(0, "sd");
    strobe(0, 8'h01, 1);
    chk("sd response", 32'(resp[0]), 32'h81);
    chk("sd unstable", 32'(unst[0]), 32'h81);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("enable low in DONE", 32'(valid[0]), 32'd1);
    en = 1'b1;
    pulse_clear();

    // timeout, ERR handling, strobe on the last timer cycle
    do_start(0, 8'h3E);
    wait_req(0, "to");
    t0 = cyc;
    w  = 0;
    while (!err[0] && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("timeout latency", 32'(cyc - t0), 32'd16);
    chk("timeout err", 32'(err[0]), 32'd1);
    chk("timeout busy", 32'(busy[0]), 32'd0);
    do_start(0, 8'h99);
    chk("start in ERR busy", 32'(busy[0]), 32'd0);
    chk("start in ERR challenge", 32'(cchal[0]), 32'h3E);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("enable low in ERR", 32'(err[0]), 32'd1);
    pulse_clear();
    chk("clear err", 32'(err[0]), 32'd0);
    do_start(0, 8'h44);
    chk("restart after ERR", 32'(busy[0]), 32'd1);
    wait_req(0, "sw");
    strobe(0, 8'h11, 15);
    chk("strobe beats timeout err", 32'(err[0]), 32'd0);
    wait_req(0, "sw");
    strobe(0, 8'h13, 2);
    wait_req(0, "sw");
    strobe(0, 8'h11, 4);
    chk("sw valid", 32'(valid[0]), 32'd1);
    chk("sw response", 32'(resp[0]), 32'h11);
    chk("sw unstable", 32'(unst[0]), 32'h02);
    pulse_clear();
    rv_s[0] = 1'b1; rd_s[0] = 8'hFF;
    @(negedge clk);
    rv_s[0] = 1'b0;
    chk("strobe in IDLE err", 32'(err[0]), 32'd0);
    chk("strobe in IDLE busy", 32'(busy[0]), 32'd0);

    // abort by enable after the first strobe
    do_start(0, 8'h42);
    wait_req(0, "ab");
    repeat (2) @(negedge clk);
    rv_s[0] = 1'b1; rd_s[0] = 8'hFF;
    @(posedge clk);
    #1;
    rv_s[0] = 1'b0;
    en = 1'b0;
    base = reqcnt[0];
    repeat (20) @(negedge clk);
    chk("abort no core_req", 32'(reqcnt[0] - base), 32'd0);
    chk("abort valid", 32'(valid[0]), 32'd0);
    chk("abort err", 32'(err[0]), 32'd0);
    chk("abort busy", 32'(busy[0]), 32'd0);
    chk("abort keeps response", 32'(resp[0]), 32'h11);
    chk("abort keeps unstable", 32'(unst[0]), 32'h02);
    en = 1'b1;
    @(negedge clk);
    r = '{8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};
    model(r, NRA, er, eu, rounds);
    run_txn(0, r, 8'h43, er, eu, rounds, "post-abort");
    pulse_clear();

    // randomized transactions on the 3-round instance
    for (int t = 0; t < 25; t++) begin
      for (int j = 0; j < 5; j++) r[j] = RW'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        r[1] = r[0];
        if ($urandom_range(0, 1) == 1) r[2] = r[0];
      end
      model(r, NRA, er, eu, rounds);
      run_txn(0, r, CW'($urandom), er, eu, rounds, "rnd");
      if ($urandom_range(0, 1) == 1) begin
        strobe(0, RW'($urandom), 1);
        chk("rnd spurious strobe response", 32'(resp[0]), 32'(er));
        chk("rnd spurious strobe valid", 32'(valid[0]), 32'd1);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_clear();
        chk("rnd clear", 32'(valid[0]), 32'd0);
      end
    end

    // 5-round instance: identical responses, then random ones
    r = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    run_txn(1, r, 8'h5C, 8'h3C, 8'h00, EE ? 3 : 5, "n5 same");
    pulse_clear();
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 5; j++) r[j] = RW'($urandom);
      if (t % 2 == 0) begin
        r[1] = r[0];
        r[2] = r[0];
      end
      model(r, NRB, er, eu, rounds);
      run_txn(1, r, CW'($urandom), er, eu, rounds, "n5 rnd");
      pulse_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1);
  end

endmodule
